axis_capture_stamper: RTL and testbench
=======================================

# axis_capture_stamper

Capture stage between a DUT AXI4-Stream master port (DMA or PHY side) and the testbench file writer. Accepts beats under a programmable ready-throttle pattern, checks tkeep legality, stamps each beat with an absolute cycle time and an idle-gap count, and buffers the resulting records in a FIFO. The file writer drains records through a valid/ready interface and turns time/gap fields into `@`/`+` delay commands in the output axi file.

## Interface
Parameters:
- W_DATA, 512, stream data width
- W_KEEP, W_DATA/8, keep width
- W_TIME, 32, width of cycle stamp and gap fields
- FIFO_DEPTH, 16, record FIFO depth (power of 2, ≥2)

Ports:
- axis_aclk  in  1  single clock for all logic
- axis_aresetn  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tdata  in  W_DATA  beat data
- s_axis_tkeep  in  W_KEEP  byte enables
- s_axis_tlast  in  1  end of packet
- s_axis_tready  out  1  beat accepted when high with tvalid
- throttle_en  in  1  enable ready-pattern throttling
- throttle_mask  in  16  ready pattern, bit i = ready allowed in pattern slot i
- rec_valid  out  1  record available
- rec_ready  in  1  writer consumes record
- rec_data  out  W_DATA  captured tdata
- rec_keep  out  W_KEEP  captured tkeep
- rec_last  out  1  captured tlast
- rec_keep_err  out  1  tkeep illegal for this beat
- rec_time  out  W_TIME  cycle stamp at acceptance
- rec_gap  out  W_TIME  idle cycles before this beat
- stat_beats  out  32  accepted beats, wrapping
- stat_packets  out  32  accepted tlast beats, wrapping
- stat_keep_errs  out  16  keep errors, saturating

## Operation
- Cycle counter `now`: 0 at reset, +1 every cycle, wraps at 2^W_TIME.
- Pattern slot `idx` (4 bits): 0 at reset, +1 every cycle, wraps 15→0.
- s_axis_tready = !fifo_full && (!throttle_en || throttle_mask[idx]). Combinational from registered state only; never depends on s_axis_tvalid.
- Accept = tvalid && tready. On accept, push record {tdata, tkeep, tlast, keep_err, now, gap}.
- Gap counter: 0 at reset; on accept it is captured as rec_gap and cleared to 0; otherwise +1 per cycle, saturating at all-ones. First beat after reset has gap = cycles since reset deassertion.
- keep_err: non-last beat with tkeep ≠ all-ones; last beat with tkeep not of form 2^k−1, 1≤k≤W_KEEP (zero is an error).
- Stats update on accept; stat_keep_errs holds at 0xFFFF.
- FIFO: first-word fall-through; rec_valid = !empty; pop on rec_valid && rec_ready.

## Timing
- Reset values: s_axis_tready 0, rec_valid 0, all rec_* 0, all stats 0; FIFO emptied.
- Latency: beat accepted at cycle N → rec_valid high with that record at N+1 (empty FIFO).
- Full: tready low while count = FIFO_DEPTH, even if a pop occurs the same cycle; tready returns the cycle after the pop.
- Simultaneous push and pop when non-empty, non-full: count unchanged, ordering preserved.
- rec_* stable while rec_valid && !rec_ready.
- Reset asserted mid-operation: all state cleared asynchronously; records in flight are discarded; `now`, `idx`, gap restart from 0 on deassertion.
- throttle_en/throttle_mask sampled combinationally each cycle; changes take effect same cycle.

## Structure
- Shared package: W_DATA/W_KEEP (existing), new packed struct `axis_rec_t` {data, keep, last, keep_err, time, gap} and function `keep_is_legal(keep, last)` for reuse by the file writer checks.
- One sub-module: `capture_fifo`, synchronous FWFT FIFO of `axis_rec_t`, parameter DEPTH, outputs full/empty/count.

## Test plan
- Reset release, tvalid high with 3-beat packet (tkeep all-ones, all-ones, 0x0F), rec_ready=1, throttle off → records at cycles 1,2,3 after acceptance, gaps 0/0/0 after first, rec_last on beat 3, stat_packets=1, no keep_err.
- throttle_en=1, mask=0x5555, continuous tvalid → tready alternates 1/0 with idx; every record after the first has gap=1.
- rec_ready=0, push 16 beats → 16th accepted, tready low thereafter; raise rec_ready one cycle → tready high next cycle; records drained in order with increasing rec_time.
- Non-last beat tkeep=0x7F…, last beat tkeep=0x0101… and tkeep=0 → rec_keep_err=1 on each; stat_keep_errs=3.
- 20 idle cycles then one beat → rec_gap=20; assert axis_aresetn low mid-drain → rec_valid and tready 0 immediately, stats 0, next beat after release has rec_time equal to cycles since release.

Source files
------------

// File: rtl/axis_capture_stamper_pkg.sv
// Shared record format for the AXI-Stream capture path and the tkeep legality rule
// used both at capture time and by the file writer checks.
package axis_capture_stamper_pkg;

   localparam int W_DATA = 512;
   localparam int W_KEEP = W_DATA / 8;
   localparam int W_TIME = 32;

   // "time" is a reserved word, so the cycle stamp field is called tstamp.
   typedef struct packed {
      logic [W_DATA-1:0] data;
      logic [W_KEEP-1:0] keep;
      logic              last;
      logic              keep_err;
      logic [W_TIME-1:0] tstamp;
      logic [W_TIME-1:0] gap;
   } axis_rec_t;

   // Non-last beats must be full; a last beat must be a non-empty low-aligned run of ones.
   function automatic logic keep_is_legal(input logic [W_KEEP-1:0] keep, input logic last);
      if (!last) begin
         return &keep;
      end
      return (keep != '0) && ((keep & (keep + W_KEEP'(1))) == '0);
   endfunction

endpackage

// File: rtl/axis_capture_stamper_capture_fifo.sv
// First-word-fall-through record FIFO: a push is visible on the output the next cycle,
// and a push while full is ignored; output reads as zero while empty.
module capture_fifo
   import axis_capture_stamper_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  axis_rec_t                push_dat_i,
   input  logic                     pop_i,
   output axis_rec_t                pop_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   axis_rec_t         mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push, do_pop;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: the empty mask hides stale entries.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/axis_capture_stamper.sv
// Stamps accepted AXI-Stream beats with cycle time and idle gap into a FWFT record FIFO.
// Record visible one cycle after acceptance; tready drops while the FIFO is full or throttled.
module axis_capture_stamper #(
   parameter int W_DATA     = axis_capture_stamper_pkg::W_DATA,
   parameter int W_KEEP     = W_DATA / 8,
   parameter int W_TIME     = axis_capture_stamper_pkg::W_TIME,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              axis_aclk,
   input  logic              axis_aresetn,
   input  logic              s_axis_tvalid,
   input  logic [W_DATA-1:0] s_axis_tdata,
   input  logic [W_KEEP-1:0] s_axis_tkeep,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   input  logic              throttle_en,
   input  logic [15:0]       throttle_mask,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [W_DATA-1:0] rec_data,
   output logic [W_KEEP-1:0] rec_keep,
   output logic              rec_last,
   output logic              rec_keep_err,
   output logic [W_TIME-1:0] rec_time,
   output logic [W_TIME-1:0] rec_gap,
   output logic [31:0]       stat_beats,
   output logic [31:0]       stat_packets,
   output logic [15:0]       stat_keep_errs
);
   import axis_capture_stamper_pkg::*;

   logic [W_TIME-1:0] now_q, now_d;
   logic [W_TIME-1:0] gap_q, gap_d;
   logic [3:0]        idx_q, idx_d;
   logic [31:0]       beats_q, beats_d, pkts_q, pkts_d;
   logic [15:0]       kerrs_q, kerrs_d;

   logic              fifo_full, fifo_empty, accept, keep_err;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   axis_rec_t         push_rec, head_rec;

   // Gating with the reset pin keeps tready low while reset is held.
   assign s_axis_tready = axis_aresetn && !fifo_full && (!throttle_en || throttle_mask[idx_q]);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign keep_err      = !keep_is_legal(s_axis_tkeep, s_axis_tlast);

   always_comb begin
      push_rec          = '0;
      push_rec.data     = s_axis_tdata;
      push_rec.keep     = s_axis_tkeep;
      push_rec.last     = s_axis_tlast;
      push_rec.keep_err = keep_err;
      push_rec.tstamp   = now_q;
      push_rec.gap      = gap_q;
   end

   always_comb begin
      now_d   = now_q + W_TIME'(1);
      idx_d   = idx_q + 4'd1;
      gap_d   = (&gap_q) ? gap_q : gap_q + W_TIME'(1);
      beats_d = beats_q;
      pkts_d  = pkts_q;
      kerrs_d = kerrs_q;
      if (accept) begin
         gap_d   = '0;
         beats_d = beats_q + 32'd1;
         if (s_axis_tlast) pkts_d = pkts_q + 32'd1;
         if (keep_err && !(&kerrs_q)) kerrs_d = kerrs_q + 16'd1;
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         now_q   <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         beats_q <= '0;
         pkts_q  <= '0;
         kerrs_q <= '0;
      end else begin
         now_q   <= now_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         beats_q <= beats_d;
         pkts_q  <= pkts_d;
         kerrs_q <= kerrs_d;
      end
   end

   capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (axis_aclk),
      .rst_n      (axis_aresetn),
      .push_i     (accept),
      .push_dat_i (push_rec),
      .pop_i      (rec_ready),
      .pop_dat_o  (head_rec),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign rec_valid      = !fifo_empty;
   assign rec_data       = head_rec.data;
   assign rec_keep       = head_rec.keep;
   assign rec_last       = head_rec.last;
   assign rec_keep_err   = head_rec.keep_err;
   assign rec_time       = head_rec.tstamp;
   assign rec_gap        = head_rec.gap;
   assign stat_beats     = beats_q;
   assign stat_packets   = pkts_q;
   assign stat_keep_errs = kerrs_q;

endmodule

// File: tb/tb_axis_capture_stamper.sv
// Directed bench: per-cycle vector table for the basic packet and tkeep cases, then
// hand sequences for throttling, FIFO full, idle gap and mid-drain reset.
module tb_axis_capture_stamper;

   localparam logic [63:0] K1  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] K0F = 64'h0000_0000_0000_000F;
   localparam logic [63:0] K7F = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] K01 = 64'h0101_0101_0101_0101;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tvalid, tlast, tready;
   logic [511:0]  tdata;
   logic [63:0]   tkeep;
   logic          thr_en;
   logic [15:0]   thr_mask;
   logic          rvld, rrdy, rlast, rkerr;
   logic [511:0]  rdata;
   logic [63:0]   rkeep;
   logic [31:0]   rtime, rgap, s_beats, s_pkts;
   logic [15:0]   s_kerrs;

   always #5 clk = ~clk;

   axis_capture_stamper dut (
      .axis_aclk      (clk),
      .axis_aresetn   (rst_n),
      .s_axis_tvalid  (tvalid),
      .s_axis_tdata   (tdata),
      .s_axis_tkeep   (tkeep),
      .s_axis_tlast   (tlast),
      .s_axis_tready  (tready),
      .throttle_en    (thr_en),
      .throttle_mask  (thr_mask),
      .rec_valid      (rvld),
      .rec_ready      (rrdy),
      .rec_data       (rdata),
      .rec_keep       (rkeep),
      .rec_last       (rlast),
      .rec_keep_err   (rkerr),
      .rec_time       (rtime),
      .rec_gap        (rgap),
      .stat_beats     (s_beats),
      .stat_packets   (s_pkts),
      .stat_keep_errs (s_kerrs)
   );

   typedef struct {
      logic        vld;
      logic [63:0] keep;
      logic        last;
      logic [31:0] dat;
      logic        e_rdy;
      logic        e_rvld;
      logic [31:0] e_dat;
      logic [63:0] e_keep;
      logic        e_last;
      logic        e_kerr;
      int          e_time;
      int          e_gap;
      int          e_beats;
      int          e_pkts;
      int          e_kerrs;
   } vec_t;

   vec_t vt [9];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [511:0] fill(input logic [31:0] v);
      return {16{v}};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic beat(input logic v, input logic [63:0] k, input logic l, input logic [31:0] d);
      tvalid = v;
      tkeep  = k;
      tlast  = l;
      tdata  = fill(d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        prev_acc;
      logic        first_rec;
      logic        exp_rdy;
      int          q[$];
      int          t_b;

      //             vld keep last dat   rdy rvld e_dat e_keep last kerr time gap beats pkts kerrs
      vt[0] = '{1'b1, K1,  1'b0, 32'h11, 1'b1, 1'b0, 32'h0,  64'h0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
      vt[1] = '{1'b1, K1,  1'b0, 32'h22, 1'b1, 1'b1, 32'h11, K1,    1'b0, 1'b0, 0, 0, 1, 0, 0};
      vt[2] = '{1'b1, K0F, 1'b1, 32'h33, 1'b1, 1'b1, 32'h22, K1,    1'b0, 1'b0, 1, 0, 2, 0, 0};
      vt[3] = '{1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h33, K0F,  1'b1, 1'b0, 2, 0, 3, 1, 0};
      vt[4] = '{1'b1, K7F, 1'b0, 32'h44, 1'b1, 1'b0, 32'h0,  64'h0, 1'b0, 1'b0, 0, 0, 3, 1, 0};
      vt[5] = '{1'b1, K01, 1'b1, 32'h55, 1'b1, 1'b1, 32'h44, K7F,   1'b0, 1'b1, 4, 1, 4, 1, 1};
      vt[6] = '{1'b1, 64'h0, 1'b1, 32'h66, 1'b1, 1'b1, 32'h55, K01, 1'b1, 1'b1, 5, 0, 5, 2, 2};
      vt[7] = '{1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h66, 64'h0, 1'b1, 1'b1, 6, 0, 6, 3, 3};
      vt[8] = '{1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  64'h0, 1'b0, 1'b0, 0, 0, 6, 3, 3};

      rst_n    = 1'b0;
      thr_en   = 1'b0;
      thr_mask = 16'h0;
      rrdy     = 1'b1;
      beat(1'b0, 64'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_tready", 512'(tready), 512'(0));
      chk("reset_rec_valid", 512'(rvld), 512'(0));
      chk("reset_rec_time", 512'(rtime), 512'(0));
      chk("reset_rec_data", rdata, 512'(0));
      chk("reset_stat_beats", 512'(s_beats), 512'(0));

      // Table: cycle 0 is the first clock edge after reset release.
      rst_n = 1'b1;
      cyc   = 0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) next_cycle();
         beat(vt[i].vld, vt[i].keep, vt[i].last, vt[i].dat);
         #1;
         chk($sformatf("v%0d_tready", i), 512'(tready), 512'(vt[i].e_rdy));
         chk($sformatf("v%0d_rec_valid", i), 512'(rvld), 512'(vt[i].e_rvld));
         if (vt[i].e_rvld) begin
            chk($sformatf("v%0d_rec_data", i), rdata, fill(vt[i].e_dat));
            chk($sformatf("v%0d_rec_keep", i), 512'(rkeep), 512'(vt[i].e_keep));
            chk($sformatf("v%0d_rec_last", i), 512'(rlast), 512'(vt[i].e_last));
            chk($sformatf("v%0d_rec_keep_err", i), 512'(rkerr), 512'(vt[i].e_kerr));
            chk($sformatf("v%0d_rec_time", i), 512'(rtime), 512'(vt[i].e_time));
            chk($sformatf("v%0d_rec_gap", i), 512'(rgap), 512'(vt[i].e_gap));
         end
         chk($sformatf("v%0d_stat_beats", i), 512'(s_beats), 512'(vt[i].e_beats));
         chk($sformatf("v%0d_stat_packets", i), 512'(s_pkts), 512'(vt[i].e_pkts));
         chk($sformatf("v%0d_stat_keep_errs", i), 512'(s_kerrs), 512'(vt[i].e_kerrs));
      end

      // Throttle 0x5555: ready only in even pattern slots; slot = cycles since reset mod 16.
      prev_acc  = 1'b0;
      first_rec = 1'b1;
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         thr_en   = 1'b1;
         thr_mask = 16'h5555;
         beat(1'b1, K1, 1'b0, 32'(cyc));
         #1;
         exp_rdy = ((cyc % 16) % 2) == 0;
         chk("thr_tready", 512'(tready), 512'(exp_rdy));
         chk("thr_rec_valid", 512'(rvld), 512'(prev_acc));
         if (prev_acc) begin
            chk("thr_rec_time", 512'(rtime), 512'(cyc - 1));
            if (!first_rec) chk("thr_rec_gap", 512'(rgap), 512'(1));
            first_rec = 1'b0;
         end
         prev_acc = exp_rdy;
      end
      next_cycle();
      thr_en = 1'b0;
      beat(1'b0, 64'h0, 1'b0, 32'h0);
      #1;
      chk("thr_last_rec_valid", 512'(rvld), 512'(prev_acc));
      if (prev_acc) chk("thr_last_rec_gap", 512'(rgap), 512'(1));

      // Fill the FIFO with the writer stalled.
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         rrdy = 1'b0;
         beat(1'b1, K1, 1'b0, 32'(cyc));
         #1;
         chk("fill_tready", 512'(tready), 512'(1));
         q.push_back(cyc);
      end
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         #1;
         chk("full_tready", 512'(tready), 512'(0));
         chk("full_rec_valid", 512'(rvld), 512'(1));
         chk("full_rec_time_stable", 512'(rtime), 512'(q[0]));
      end
      next_cycle();
      rrdy = 1'b1;
      #1;
      chk("full_pop_tready", 512'(tready), 512'(0));
      chk("full_pop_rec_time", 512'(rtime), 512'(q[0]));
      void'(q.pop_front());
      next_cycle();
      rrdy = 1'b0;
      beat(1'b0, 64'h0, 1'b0, 32'h0);
      #1;
      chk("after_pop_tready", 512'(tready), 512'(1));
      for (int k = 0; k < 15; k++) begin
         if (k > 0) next_cycle();
         if (k > 0) rrdy = 1'b1;
         if (k == 0) begin
            next_cycle();
            rrdy = 1'b1;
         end
         #1;
         chk("drain_rec_valid", 512'(rvld), 512'(1));
         chk("drain_rec_time", 512'(rtime), 512'(q[0]));
         chk("drain_rec_data", 512'(rdata[31:0]), 512'(q[0]));
         chk("drain_rec_gap", 512'(rgap), 512'(0));
         void'(q.pop_front());
      end
      next_cycle();
      #1;
      chk("drained_rec_valid", 512'(rvld), 512'(0));

      // One beat, 20 idle cycles, then a beat whose gap must be 20.
      next_cycle();
      beat(1'b1, K1, 1'b1, 32'hAA);
      #1;
      chk("gap_a_tready", 512'(tready), 512'(1));
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         beat(1'b0, 64'h0, 1'b0, 32'h0);
      end
      next_cycle();
      beat(1'b1, K1, 1'b1, 32'hBB);
      t_b = cyc;
      #1;
      chk("gap_b_tready", 512'(tready), 512'(1));
      next_cycle();
      beat(1'b0, 64'h0, 1'b0, 32'h0);
      #1;
      chk("gap_b_rec_valid", 512'(rvld), 512'(1));
      chk("gap_b_rec_gap", 512'(rgap), 512'(20));
      chk("gap_b_rec_time", 512'(rtime), 512'(t_b));

      // Reset in the middle of a drain.
      rrdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         beat(1'b1, K1, 1'b0, 32'(cyc));
      end
      next_cycle();
      beat(1'b0, 64'h0, 1'b0, 32'h0);
      rrdy = 1'b1;
      #1;
      chk("pre_rst_rec_valid", 512'(rvld), 512'(1));
      next_cycle();
      rst_n = 1'b0;
      #1;
      chk("rst_rec_valid", 512'(rvld), 512'(0));
      chk("rst_tready", 512'(tready), 512'(0));
      chk("rst_stat_beats", 512'(s_beats), 512'(0));
      chk("rst_stat_packets", 512'(s_pkts), 512'(0));
      chk("rst_rec_time", 512'(rtime), 512'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      for (int k = 0; k < 5; k++) next_cycle();
      beat(1'b1, K1, 1'b1, 32'hCC);
      #1;
      chk("post_rst_tready", 512'(tready), 512'(1));
      next_cycle();
      beat(1'b0, 64'h0, 1'b0, 32'h0);
      #1;
      chk("post_rst_rec_valid", 512'(rvld), 512'(1));
      chk("post_rst_rec_time", 512'(rtime), 512'(5));
      chk("post_rst_rec_gap", 512'(rgap), 512'(5));
      chk("post_rst_stat_beats", 512'(s_beats), 512'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
